// File: rtl/div_unit_if.sv
// Handshake and operand bundle for the iterative divider: operand sources and
// forwarding selects in, status and results out.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic             flush;
   logic [WIDTH-1:0] reg1;
   logic [WIDTH-1:0] reg2;
   logic [WIDTH-1:0] alu_result;
   logic             forwardA;
   logic             forwardB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, is_signed, flush, reg1, reg2, alu_result, forwardA, forwardB,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, is_signed, flush, reg1, reg2, alu_result, forwardA, forwardB,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider (one quotient bit per cycle) with signed/unsigned
// modes, divide-by-zero result, flush, and a fixed WIDTH+2 cycle latency.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   div_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    LAST    = CW'(WIDTH-1);

   // ARM is the capture cycle: raw operands are held, magnitudes loaded next edge
   typedef enum logic [2:0] {IDLE, ARM, RUN, FIX, DONE} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_raw_reg, b_raw_reg;
   logic [WIDTH-1:0] quo_reg, rem_reg, dvs_reg;
   logic             sgn_reg;
   logic [CW-1:0]    cnt_reg;
   logic             busy_reg, done_reg, dbz_reg;
   logic [WIDTH-1:0] q_out_reg, r_out_reg;

   logic [WIDTH-1:0] sel_a, sel_b, mag_a, mag_b;
   logic [WIDTH-1:0] q_next, r_next, q_fin, r_fin;
   logic [WIDTH:0]   trial;
   logic             neg_a, neg_b, dbz_next;

   always_comb begin
      sel_a = bus.reg1;
      sel_b = bus.reg2;
      if (bus.forwardA)
         sel_a = bus.alu_result;
      else if (bus.forwardB)
         sel_b = bus.alu_result;
   end

   always_comb begin
      neg_a = sgn_reg & a_raw_reg[WIDTH-1];
      neg_b = sgn_reg & b_raw_reg[WIDTH-1];
      mag_a = neg_a ? -a_raw_reg : a_raw_reg;
      mag_b = neg_b ? -b_raw_reg : b_raw_reg;
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      trial = {rem_reg, quo_reg[WIDTH-1]};
      if (trial >= {1'b0, dvs_reg}) begin
         r_next = trial[WIDTH-1:0] - dvs_reg;
         q_next = {quo_reg[WIDTH-2:0], 1'b1};
      end else begin
         r_next = trial[WIDTH-1:0];
         q_next = {quo_reg[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      q_fin    = (neg_a ^ neg_b) ? -quo_reg : quo_reg;
      r_fin    = neg_a ? -rem_reg : rem_reg;
      dbz_next = 1'b0;
      if (b_raw_reg == '0) begin
         q_fin    = '1;
         r_fin    = a_raw_reg;
         dbz_next = 1'b1;
      end else if (sgn_reg && (a_raw_reg == MIN_VAL) && (b_raw_reg == '1)) begin
         q_fin = MIN_VAL;
         r_fin = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_raw_reg <= '0;
         b_raw_reg <= '0;
         quo_reg   <= '0;
         rem_reg   <= '0;
         dvs_reg   <= '0;
         sgn_reg   <= 1'b0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         dbz_reg   <= 1'b0;
         q_out_reg <= '0;
         r_out_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start && !bus.flush) begin
                  a_raw_reg <= sel_a;
                  b_raw_reg <= sel_b;
                  sgn_reg   <= bus.is_signed;
                  state_reg <= ARM;
               end
            end
            ARM: begin
               if (bus.flush) begin
                  state_reg <= IDLE;
               end else begin
                  quo_reg   <= mag_a;
                  rem_reg   <= '0;
                  dvs_reg   <= mag_b;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               if (bus.flush) begin
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  quo_reg <= q_next;
                  rem_reg <= r_next;
                  cnt_reg <= cnt_reg + CW'(1);
                  if (cnt_reg == LAST)
                     state_reg <= FIX;
               end
            end
            FIX: begin
               busy_reg <= 1'b0;
               if (bus.flush) begin
                  state_reg <= IDLE;
               end else begin
                  q_out_reg <= q_fin;
                  r_out_reg <= r_fin;
                  dbz_reg   <= dbz_next;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.quotient    = q_out_reg;
   assign bus.remainder   = r_out_reg;
   assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, forwarding, start
// re-pulse, flush, async reset, then randomized divides against a plain model.
module tb_div_unit;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   div_unit_if #(.WIDTH(32)) bus ();

   div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain arithmetic on the selected operands
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        output logic [31:0] q, output logic [31:0] r, output logic z);
      z = 1'b0;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
         z = 1'b1;
      end else if (!sg) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
   endtask

   task automatic run_div(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] alu,
                          input logic fa, input logic fb, input logic sg, input int pulse_at);
      logic [31:0] a, b, eq, er;
      logic        ez;
      int          busy_n, done_n;
      a = fa ? alu : r1;
      b = fa ? r2 : (fb ? alu : r2);
      model(a, b, sg, eq, er, ez);
      bus.reg1 = r1; bus.reg2 = r2; bus.alu_result = alu;
      bus.forwardA = fa; bus.forwardB = fb; bus.is_signed = sg;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      busy_n = 0;
      done_n = 0;
      for (int k = 1; k <= 34; k++) begin
         if (k == pulse_at) begin
            bus.start = 1'b1; bus.reg1 = 32'd9; bus.reg2 = 32'd3;
            bus.forwardA = 1'b0; bus.forwardB = 1'b0;
         end
         tick();
         bus.start = 1'b0;
         if (k <= 33) begin
            if (bus.busy) busy_n++;
            if (bus.done) done_n++;
         end
      end
      chk("busy_cycles", busy_n, 33);
      chk("early_done", done_n, 0);
      chk("done", {31'd0, bus.done}, 32'd1);
      chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
      chk("quotient", bus.quotient, eq);
      chk("remainder", bus.remainder, er);
      chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, ez});
      $display("div a=%h b=%h s=%0d -> q=%h r=%h z=%0d", a, b, sg,
               bus.quotient, bus.remainder, bus.div_by_zero);
      tick();
      chk("done_pulse", {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      int done_n;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.is_signed = 1'b0; bus.flush = 1'b0;
      bus.reg1 = '0; bus.reg2 = '0; bus.alu_result = '0;
      bus.forwardA = 1'b0; bus.forwardB = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_q", bus.quotient, 32'd0);
      chk("rst_r", bus.remainder, 32'd0);
      chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);

      run_div(32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 0);
      run_div(32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 0);
      run_div(32'd7, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, 1'b1, 0);
      run_div(32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 0);
      run_div(32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 0);
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b1, 0);
      run_div(32'd999, 32'd5, 32'd50, 1'b1, 1'b0, 1'b0, 0);
      run_div(32'd999, 32'd5, 32'd50, 1'b0, 1'b1, 1'b0, 0);
      run_div(32'd999, 32'd5, 32'd50, 1'b1, 1'b1, 1'b0, 0);
      run_div(32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 10);

      // Flush mid-RUN: no pulse, previous results (14/2) retained
      bus.reg1 = 32'd9; bus.reg2 = 32'd3; bus.forwardA = 1'b0; bus.forwardB = 1'b0;
      bus.is_signed = 1'b0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (19) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush_busy", {31'd0, bus.busy}, 32'd0);
      done_n = 0;
      for (int k = 21; k <= 40; k++) begin
         tick();
         if (bus.done || bus.busy) done_n++;
      end
      chk("flush_no_done", done_n, 0);
      chk("flush_q", bus.quotient, 32'd14);
      chk("flush_r", bus.remainder, 32'd2);
      run_div(32'd1000, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0, 0);

      // start together with flush in IDLE must be ignored
      bus.start = 1'b1; bus.flush = 1'b1;
      tick();
      bus.start = 1'b0; bus.flush = 1'b0;
      tick();
      tick();
      chk("start_flush_busy", {31'd0, bus.busy}, 32'd0);

      // Async reset between edges mid-RUN
      bus.reg1 = 32'd77; bus.reg2 = 32'd4; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, bus.busy}, 32'd0);
      chk("arst_done", {31'd0, bus.done}, 32'd0);
      chk("arst_q", bus.quotient, 32'd0);
      chk("arst_r", bus.remainder, 32'd0);
      chk("arst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
      #2 rst_n = 1'b1;
      tick();
      run_div(32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] r1, r2, alu;
         int          mode;
         mode = $urandom_range(0, 3);
         r1   = $urandom;
         alu  = (mode == 1) ? 32'($urandom_range(1, 20)) : $urandom;
         case (mode)
            0:       r2 = 32'd0;
            1:       r2 = 32'($urandom_range(1, 20));
            2:       r2 = $urandom;
            default: r2 = 32'hFFFF_FFFF;
         endcase
         if ($urandom_range(0, 7) == 0) r1 = 32'h8000_0000;
         run_div(r1, r2, alu, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
